// File: rtl/tone_pkg.sv
// Shared definitions for the tone decoder: note codes, default note periods,
// FSM state encoding and the period-window helper.
package tone_pkg;

    typedef logic [2:0] noteCode_t;

    localparam noteCode_t NOTE_NONE = 3'd0;
    localparam noteCode_t NOTE_C    = 3'd1;
    localparam noteCode_t NOTE_D    = 3'd2;
    localparam noteCode_t NOTE_E    = 3'd3;
    localparam noteCode_t NOTE_G    = 3'd4;

    localparam int DEF_P_C = 61158;
    localparam int DEF_P_D = 54485;
    localparam int DEF_P_E = 48541;
    localparam int DEF_P_G = 40816;

    localparam int PERIOD_MAX = 131071;

    localparam logic [1:0] ST_SILENT = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_TRACK  = 2'd2;

    // True when period lies within +/-(nominal >> tolShift) of nominal.
    function automatic logic inWindow(input logic [16:0] period,
                                      input logic [16:0] nominal,
                                      input int          tolShift);
        logic [16:0] tol;
        logic [16:0] diff;
        tol  = nominal >> tolShift;
        diff = (period >= nominal) ? (period - nominal) : (nominal - period);
        return (diff <= tol);
    endfunction

endpackage

// File: rtl/tone_in_sync.sv
// Input conditioning for the tone decoder: 2-flop synchronizer, optional glitch
// filter (TONE_DECODER_GLITCH_FILTER_EN) and registered rising-edge pulse.
module tone_in_sync (
    input  logic CLK,
    input  logic RST_N,
    input  logic TONE_IN,
    output logic riseEdge
);

    logic sync1;
    logic sync2;
    logic levelNow;
    logic levelPrev;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= TONE_IN;
            sync2 <= sync1;
        end
    end

`ifdef TONE_DECODER_GLITCH_FILTER_EN
    // Filtered level follows sync2 only after 4 consecutive differing samples.
    logic [1:0] runCnt;
    logic       filtLevel;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            runCnt    <= 2'd0;
            filtLevel <= 1'b0;
        end else if (sync2 == filtLevel) begin
            runCnt <= 2'd0;
        end else if (runCnt == 2'd3) begin
            filtLevel <= sync2;
            runCnt    <= 2'd0;
        end else begin
            runCnt <= runCnt + 2'd1;
        end
    end

    assign levelNow = filtLevel;
`else
    assign levelNow = sync2;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            levelPrev <= 1'b0;
            riseEdge  <= 1'b0;
        end else begin
            levelPrev <= levelNow;
            riseEdge  <= levelNow & ~levelPrev;
        end
    end

endmodule

// File: rtl/tone_decoder.sv
// Measures the period of a square-wave tone and locks onto C4/D4/E4/G4.
// Optional glitch filter in tone_in_sync is enabled by TONE_DECODER_GLITCH_FILTER_EN.
module tone_decoder
    import tone_pkg::*;
#(
    parameter int P_C       = DEF_P_C,
    parameter int P_D       = DEF_P_D,
    parameter int P_E       = DEF_P_E,
    parameter int P_G       = DEF_P_G,
    parameter int TOL_SHIFT = 6,
    parameter int MATCH_N   = 2,
    // Saturation/timeout point of the period counter; lowered only to shorten simulations.
    parameter int CNT_SAT   = PERIOD_MAX
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        TONE_IN,
    output logic [2:0]  NOTE,
    output logic        NOTE_VALID,
    output logic        NOTE_STB,
    output logic [16:0] PERIOD
);

    localparam logic [16:0] SAT_VAL   = 17'(CNT_SAT);
    localparam logic [7:0]  MATCH_LIM = 8'(MATCH_N);

    logic        riseEdge;
    logic [1:0]  state;
    logic [16:0] periodCnt;
    logic [7:0]  matchCnt;
    logic [7:0]  nextCount;
    noteCode_t   prevClass;
    noteCode_t   edgeClass;
    logic        atSat;

    tone_in_sync u_sync (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .TONE_IN  (TONE_IN),
        .riseEdge (riseEdge)
    );

    assign atSat = (periodCnt == SAT_VAL);

    // A saturated measurement never matches a note, whatever the parameters.
    always_comb begin
        edgeClass = NOTE_NONE;
        if (!atSat) begin
            if (inWindow(periodCnt, 17'(P_C), TOL_SHIFT))
                edgeClass = NOTE_C;
            else if (inWindow(periodCnt, 17'(P_D), TOL_SHIFT))
                edgeClass = NOTE_D;
            else if (inWindow(periodCnt, 17'(P_E), TOL_SHIFT))
                edgeClass = NOTE_E;
            else if (inWindow(periodCnt, 17'(P_G), TOL_SHIFT))
                edgeClass = NOTE_G;
        end
    end

    always_comb begin
        nextCount = 8'd0;
        if (edgeClass != NOTE_NONE)
            nextCount = (edgeClass == prevClass) ? (matchCnt + 8'd1) : 8'd1;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= ST_SILENT;
            periodCnt  <= 17'd0;
            matchCnt   <= 8'd0;
            prevClass  <= NOTE_NONE;
            NOTE       <= NOTE_NONE;
            NOTE_VALID <= 1'b0;
            NOTE_STB   <= 1'b0;
            PERIOD     <= 17'd0;
        end else begin
            NOTE_STB <= 1'b0;
            if (state == ST_SILENT) begin
                if (riseEdge) begin
                    state     <= ST_ARMED;
                    periodCnt <= 17'd1;
                    matchCnt  <= 8'd0;
                    prevClass <= NOTE_NONE;
                end
            end else if (riseEdge) begin
                periodCnt <= 17'd1;
                PERIOD    <= periodCnt;
                if (state == ST_TRACK) begin
                    if (edgeClass != NOTE) begin
                        state      <= ST_ARMED;
                        NOTE       <= NOTE_NONE;
                        NOTE_VALID <= 1'b0;
                        NOTE_STB   <= 1'b1;
                        matchCnt   <= (edgeClass != NOTE_NONE) ? 8'd1 : 8'd0;
                        prevClass  <= edgeClass;
                    end
                end else begin
                    matchCnt  <= nextCount;
                    prevClass <= edgeClass;
                    if (edgeClass != NOTE_NONE && nextCount >= MATCH_LIM) begin
                        state      <= ST_TRACK;
                        NOTE       <= edgeClass;
                        NOTE_VALID <= 1'b1;
                        NOTE_STB   <= 1'b1;
                    end else begin
                        state <= ST_ARMED;
                    end
                end
            end else if (atSat) begin
                // Tone has stopped: drop back to idle and freeze the counter.
                state      <= ST_SILENT;
                periodCnt  <= 17'd0;
                matchCnt   <= 8'd0;
                prevClass  <= NOTE_NONE;
                NOTE       <= NOTE_NONE;
                NOTE_VALID <= 1'b0;
                NOTE_STB   <= (NOTE != NOTE_NONE);
            end else begin
                periodCnt <= periodCnt + 17'd1;
            end
        end
    end

endmodule

// File: tb/tb_tone_decoder.sv
// Self-checking bench for tone_decoder using scaled-down note periods and a
// reduced counter saturation point; follows TONE_DECODER_GLITCH_FILTER_EN if defined.
module tb_tone_decoder;

    localparam int BP_C      = 600;
    localparam int BP_D      = 535;
    localparam int BP_E      = 477;
    localparam int BP_G      = 401;
    localparam int TOL       = 6;
    localparam int MATCHES   = 2;
    localparam int SAT       = 3000;
    localparam int CHECK_LAG = 12;

    logic        CLK;
    logic        RST_N;
    logic        TONE_IN;
    logic [2:0]  NOTE;
    logic        NOTE_VALID;
    logic        NOTE_STB;
    logic [16:0] PERIOD;

    int vectors     = 0;
    int miscompares = 0;
    int cycleNo     = 0;
    int riseCycle   = 0;
    int stbSeen     = 0;

    // Reference model: silence flag, locked note, current run of equal classes.
    bit mSilent   = 1'b1;
    int mLocked   = 0;
    int mRunClass = 0;
    int mRunLen   = 0;
    int mPeriod   = 0;
    int stbExp    = 0;

    int nominal [5] = '{0, BP_C, BP_D, BP_E, BP_G};

    tone_decoder #(
        .P_C       (BP_C),
        .P_D       (BP_D),
        .P_E       (BP_E),
        .P_G       (BP_G),
        .TOL_SHIFT (TOL),
        .MATCH_N   (MATCHES),
        .CNT_SAT   (SAT)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .TONE_IN    (TONE_IN),
        .NOTE       (NOTE),
        .NOTE_VALID (NOTE_VALID),
        .NOTE_STB   (NOTE_STB),
        .PERIOD     (PERIOD)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cycleNo <= cycleNo + 1;

    // Strobe monitor: NOTE changes exactly when a lone one-cycle strobe fires.
    logic [2:0] notePrev = 3'd0;
    logic       stbPrev  = 1'b0;
    logic       rstPrev  = 1'b0;
    always @(negedge CLK) begin
        if (NOTE_STB === 1'b1) stbSeen++;
        if (RST_N && rstPrev && ((NOTE !== notePrev) || (NOTE_STB === 1'b1))) begin
            vectors++;
            assert ((NOTE !== notePrev) && (NOTE_STB === 1'b1) && (stbPrev === 1'b0))
            else begin
                miscompares++;
                $error("[TB] FAIL stbRule: note %0d->%0d stb=%b prevStb=%b",
                       notePrev, NOTE, NOTE_STB, stbPrev);
            end
        end
        notePrev = NOTE;
        stbPrev  = NOTE_STB;
        rstPrev  = RST_N;
    end

    function automatic int classify(input int p);
        int d;
        if (p >= SAT) return 0;
        for (int n = 1; n <= 4; n++) begin
            d = p - nominal[n];
            if (d < 0) d = -d;
            if (d <= (nominal[n] >> TOL)) return n;
        end
        return 0;
    endfunction

    function automatic void modelEdge(input int p);
        int cls;
        if (mSilent) begin
            mSilent   = 1'b0;
            mRunClass = 0;
            mRunLen   = 0;
            return;
        end
        mPeriod = (p > SAT) ? SAT : p;
        cls     = classify(p);
        if (mLocked != 0) begin
            if (cls != mLocked) begin
                mLocked   = 0;
                stbExp++;
                mRunClass = cls;
                mRunLen   = (cls != 0) ? 1 : 0;
            end
        end else begin
            if (cls != 0 && cls == mRunClass) begin
                mRunLen++;
            end else begin
                mRunClass = cls;
                mRunLen   = (cls != 0) ? 1 : 0;
            end
            if (cls != 0 && mRunLen >= MATCHES) begin
                mLocked = cls;
                stbExp++;
            end
        end
    endfunction

    function automatic void modelTimeout();
        if (mLocked != 0) stbExp++;
        mLocked = 0;
        mSilent = 1'b1;
    endfunction

    function automatic void modelReset();
        mLocked   = 0;
        mSilent   = 1'b1;
        mRunClass = 0;
        mRunLen   = 0;
        mPeriod   = 0;
    endfunction

    task automatic waitCycles(input int n);
        if (n > 0) begin
            repeat (n) @(posedge CLK);
            #1;
        end
    endtask

    task automatic compare(input string tag, input string field,
                           input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s.%s: observed %0d expected %0d", tag, field, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        compare(tag, "note",   32'(NOTE),       32'(mLocked));
        compare(tag, "valid",  32'(NOTE_VALID), 32'(mLocked != 0));
        compare(tag, "period", 32'(PERIOD),     32'(mPeriod));
        compare(tag, "stbCnt", 32'(stbSeen),    32'(stbExp));
    endtask

    // One full period starting with a rising edge; optional 2-cycle pulse in the low half.
    task automatic applyStimulus(input string tag, input int p, input bit glitch);
        int h;
        int lo;
        int g;
        h  = p / 2;
        lo = p - h;
        TONE_IN = 1'b1;
        modelEdge(cycleNo - riseCycle);
        riseCycle = cycleNo;
        waitCycles(CHECK_LAG);
        checkOutput(tag);
        waitCycles(h - CHECK_LAG);
        TONE_IN = 1'b0;
        if (glitch) begin
            g = lo / 2;
            waitCycles(g);
            TONE_IN = 1'b1;
`ifndef TONE_DECODER_GLITCH_FILTER_EN
            modelEdge(cycleNo - riseCycle);
            riseCycle = cycleNo;
`endif
            waitCycles(2);
            TONE_IN = 1'b0;
            waitCycles(CHECK_LAG);
            checkOutput({tag, "Glitch"});
            waitCycles(lo - g - 2 - CHECK_LAG);
        end else begin
            waitCycles(lo);
        end
    endtask

    task automatic awaitTimeout(input string tag);
        waitCycles(riseCycle + SAT - 10 - cycleNo);
        checkOutput({tag, "Pre"});
        waitCycles(40);
        modelTimeout();
        checkOutput(tag);
    endtask

    initial begin
        int p;
        int note;
        int tol;
        RST_N   = 1'b0;
        TONE_IN = 1'b0;
        waitCycles(3);
        modelReset();
        checkOutput("reset");
        compare("reset", "stb", 32'(NOTE_STB), 32'd0);
        RST_N = 1'b1;
        waitCycles(2);

        for (int i = 0; i < 5; i++) applyStimulus("c4", BP_C, 1'b0);
        compare("c4Lock", "note", 32'(NOTE), 32'd1);

        for (int i = 0; i < 3; i++) applyStimulus("d4", BP_D, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus("e4", BP_E, 1'b0);
        compare("e4Lock", "note", 32'(NOTE), 32'd3);

        for (int i = 0; i < 4; i++) applyStimulus("offKey", 570, 1'b0);

        for (int i = 0; i < 3; i++) applyStimulus("winHigh", BP_C + (BP_C >> TOL), 1'b0);
        applyStimulus("winOut", BP_C + (BP_C >> TOL) + 1, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus("winLow", BP_C - (BP_C >> TOL), 1'b0);

        for (int i = 0; i < 3; i++) applyStimulus("g4", BP_G, 1'b0);
        awaitTimeout("g4Timeout");

        for (int i = 0; i < 3; i++) applyStimulus("d4Pre", BP_D, 1'b0);
        TONE_IN = 1'b1;
        modelEdge(cycleNo - riseCycle);
        riseCycle = cycleNo;
        waitCycles(BP_D / 2);
        TONE_IN = 1'b0;
        waitCycles(100);
        RST_N = 1'b0;
        waitCycles(1);
        modelReset();
        checkOutput("midReset");
        compare("midReset", "stb", 32'(NOTE_STB), 32'd0);
        RST_N = 1'b1;
        waitCycles(150);
        for (int i = 0; i < 3; i++) applyStimulus("d4Relock", BP_D, 1'b0);

        for (int i = 0; i < 3; i++) applyStimulus("c4Clean", BP_C, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus("c4Glitch", BP_C, 1'b1);

        for (int b = 0; b < 10; b++) begin
            note = int'($urandom_range(0, 4));
            for (int r = 0; r < int'($urandom_range(1, 3)); r++) begin
                if (note == 0) begin
                    p = int'($urandom_range(380, 620));
                end else begin
                    tol = nominal[note] >> TOL;
                    p   = nominal[note] + int'($urandom_range(0, 2 * tol)) - tol;
                end
                applyStimulus("random", p, 1'b0);
            end
        end
        awaitTimeout("finalTimeout");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
